// File: rtl/approx_add_pkg.sv
// Shared types and constants for controllers that time-multiplex the approximate adder.
package approx_add_pkg;
  localparam int ADD_W     = 16;
  localparam int SUM_W     = ADD_W + 1;
  localparam int TAG_MAX_W = 3;

  typedef struct packed {
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
  } add_req_t;

  typedef struct packed {
    logic [SUM_W-1:0]     sum;
    logic [TAG_MAX_W-1:0] id;
  } add_rsp_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/approx_add_share_ctrl_rr_arb.sv
// Round-robin arbiter: search starts at ptr and wraps; gnt is one-hot when en, else zero.
module rr_arb
  import approx_add_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);
  logic             found;
  logic [IDX_W:0]   cand;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit holds ptr+k before the modulo-N wrap.
      cand = (IDX_W+1)'(ptr) + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
    if (en && found) gnt[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/approx_add_share_ctrl.sv
// Shares one external approximate adder between NREQ requesters through a 2-stage pipeline.
// Optional error monitor (exact reference, err_cnt/err_max) enabled by APPROX_ERR_MON_EN.
module approx_add_share_ctrl
  import approx_add_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = ADD_W,
  parameter int ID_W = clog2_min1(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W:0]        add_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W:0]        rsp_sum,
  output logic [ID_W-1:0]   rsp_id,
  output logic              busy
`ifdef APPROX_ERR_MON_EN
  ,
  output logic [15:0]       err_cnt,
  output logic [W:0]        err_max
`endif
);
  logic            s1_vld, s2_vld;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] ptr_next;
  logic            s2_free, s1_adv, s1_free, xfer;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*W +: W];
      assign b_arr[gi] = req_b[gi*W +: W];
    end
  endgenerate

  assign s2_free = !s2_vld || rsp_ready;
  assign s1_adv  = s1_vld && s2_free;
  assign s1_free = !s1_vld || s1_adv;

  // Grants are suppressed while reset is held so nothing appears accepted.
  rr_arb #(.N(NREQ), .IDX_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (s1_free && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign ptr_next  = (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s1_id   <= '0;
      rr_ptr  <= '0;
      add_a   <= '0;
      add_b   <= '0;
      rsp_sum <= '0;
      rsp_id  <= '0;
    end else begin
      if (xfer) begin
        add_a  <= a_arr[gnt_idx];
        add_b  <= b_arr[gnt_idx];
        s1_id  <= gnt_idx;
        rr_ptr <= ptr_next;
        s1_vld <= 1'b1;
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end
      // Adder output is captured as-is; approximation error is intentionally kept.
      if (s1_adv) begin
        rsp_sum <= add_o;
        rsp_id  <= s1_id;
        s2_vld  <= 1'b1;
      end else if (rsp_ready) begin
        s2_vld  <= 1'b0;
      end
    end
  end

  assign rsp_valid = s2_vld;
  assign busy      = s1_vld || s2_vld;

`ifdef APPROX_ERR_MON_EN
  logic [W:0] exact_s2;
  logic [W:0] err_diff;

  assign err_diff = (rsp_sum >= exact_s2) ? (rsp_sum - exact_s2) : (exact_s2 - rsp_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact_s2 <= '0;
      err_cnt  <= '0;
      err_max  <= '0;
    end else begin
      if (s1_adv) exact_s2 <= {1'b0, add_a} + {1'b0, add_b};
      if (rsp_valid && rsp_ready && (rsp_sum != exact_s2)) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (err_diff > err_max)  err_max <= err_diff;
      end
    end
  end
`endif
endmodule

// File: doc/approx_add_share_ctrl.md
Name: approx_add_share_ctrl

Overview:
- Time-multiplexes one 16-bit approximate unsigned adder (17-bit result, combinational, instantiated outside this block) between NREQ requesters.
- Round-robin arbitration, a 2-stage valid/ready pipeline (operand register -> adder -> result register), and a tag on every result.
- Sits between the accelerator's operand sources and the shared approximate adder in the FPGA datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand width; the result is W+1 bits.
- ID_W, $clog2(NREQ), width of the requester tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*W  packed operand A; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  packed operand B; same packing.
- add_a  out  W  operand A driven to the shared adder (stage-1 register).
- add_b  out  W  operand B driven to the shared adder.
- add_o  in  W+1  adder result, combinational from add_a/add_b.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer accept.
- rsp_sum  out  W+1  registered add_o.
- rsp_id  out  ID_W  index of the requester that issued the result.
- busy  out  1  high when either pipeline stage holds a valid entry.

Behaviour:
- Reset (async assert, sync release):
  - s1_vld = s2_vld = 0; add_a, add_b, rsp_sum, rsp_id = 0.
  - rr_ptr = 0; req_ready = 0; rsp_valid = 0; busy = 0.
- Arbitration (combinational):
  - Search starts at rr_ptr and wraps modulo NREQ; the first i with req_valid[i]=1 wins.
  - req_ready[winner] = 1 only when s1_free = !s1_vld | s1_adv. All other bits are 0.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. On transfer:
  - the operands load into add_a/add_b and the tag into s1_id; s1_vld = 1;
  - rr_ptr = (winner+1) mod NREQ. rr_ptr is unchanged on cycles with no transfer.
- Stage 2:
  - s2_free = !s2_vld | rsp_ready.
  - s1_adv = s1_vld & s2_free. On s1_adv: rsp_sum <= add_o, rsp_id <= s1_id, s2_vld <= 1.
  - If s2 is consumed with no s1_adv, s2_vld <= 0. If s1 advances with no new transfer, s1_vld <= 0.
- Latency: the result appears 2 cycles after the request handshake. Throughput is 1 result/cycle when rsp_ready is held high.
- Stall: with rsp_valid=1 and rsp_ready=0, rsp_sum and rsp_id hold stable and both stages freeze. Once s1 is full, req_ready is all zero.
- Arithmetic: rsp_sum is passed from add_o unmodified. No correction is applied, so approximation errors are preserved by design. The bit-W carry-out is retained.
- Requester rules:
  - Requesters must hold req_a/req_b stable while valid and unaccepted.
  - Deasserting req_valid before acceptance is legal; that requester simply loses its turn.
- Order: results leave in grant order.
- Reset mid-operation drops in-flight entries with no response. The requester's handshake is considered complete.
- busy = s1_vld | s2_vld.

Optional Feature:
- Macro: APPROX_ERR_MON_EN.
- Defined:
  - An internal exact W-bit adder computes a stage-1 reference, registered alongside rsp_sum.
  - Adds output err_cnt [15:0]: saturating count of consumed results where rsp_sum != exact. Reset 0; it holds at 16'hFFFF.
  - Adds output err_max [W:0]: largest |rsp_sum - exact| among consumed results. Reset 0.
  - Counting occurs only on the rsp_valid & rsp_ready cycle.
- Undefined: neither port exists, and no exact adder is synthesized.

Decomposition:
- Package approx_add_pkg:
  - constants ADD_W=16 and SUM_W=17;
  - typedef add_req_t {a, b} and typedef add_rsp_t {sum, id};
  - a function clog2_min1.
- One sub-module, rr_arb, with ports req, ptr, en -> gnt one-hot and gnt_idx. It is reusable by other shared-resource controllers.

Test Plan:
- Single request, exact stub adder:
  - Stimulus: req 1, a=16'h1234, b=16'h0F0F, rsp_ready=1.
  - Response: req_ready[1] on the same cycle; 2 cycles later rsp_valid=1, rsp_sum=17'h02143, rsp_id=1.
- All four valid continuously from reset, rsp_ready=1:
  - Response: grants 0,1,2,3,0,… one per cycle; rsp_id follows the same sequence with 2-cycle lag.
- Backpressure:
  - Stimulus: after 2 grants, rsp_ready=0 for 5 cycles.
  - Response: rsp_sum/rsp_id stable; req_ready all zero from the 3rd cycle; no lost or duplicated results after release.
- Carry-out and wrap:
  - Stimulus: a=16'hFFFF, b=16'h0001 with the exact stub.
  - Response: rsp_sum=17'h10000. Then with rr_ptr=3 and only req 0 valid, req 0 is granted and rr_ptr becomes 1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while s1 and s2 are valid.
  - Response: rsp_valid and busy go to 0 asynchronously; after release, the first grant goes to req 0.
- APPROX_ERR_MON_EN, stub adder returning exact+40 on every add:
  - Stimulus: 3 consumed results.
  - Response: err_cnt=3, err_max=40.
